bias_weight_trainer: RTL and testbench

Training stage downstream of the bias-free neural predictor's bias weight table. Records every bias lookup (index plus the 2-bit weight the table returns one cycle later) in an in-order in-flight queue. On branch resolution it computes the saturated new weight and drives the table's write port (`index_update`, `weight_update`, `en_1`). A pipeline flush squashes all younger in-flight lookups.

---
 rtl/bias_pkg.sv | 20 ++
 rtl/bias_inflight_fifo.sv | 92 +++++++++
 rtl/bias_weight_trainer.sv | 89 ++++++++
 tb/tb_bias_weight_trainer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// Shared types and the saturating update rule for the bias weight trainer.
package bias_pkg;
  localparam int BIAS_IDX_W = 10;
  localparam int BIAS_W_W = 2;
  localparam logic [BIAS_W_W-1:0] BIAS_W_MAX = 2'd3;

  typedef struct packed {
    logic [BIAS_IDX_W:1] idx;
    logic [BIAS_W_W:1]   w;
  } bias_entry_t;

  function automatic logic [BIAS_W_W-1:0] bias_sat_update(input logic [BIAS_W_W-1:0] w,
                                                          input logic taken);
    logic [BIAS_W_W-1:0] r;
    r = w;
    if (taken && w != BIAS_W_MAX) r = w + 1'b1;
    else if (!taken && w != '0) r = w - 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/bias_inflight_fifo.sv
// In-order in-flight lookup queue; weight lands one cycle after the push (head bypass covers it).
// Push/pop/flush act at the edge; push is ignored when full, pop ignored when empty.
module bias_inflight_fifo
  import bias_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = BIAS_IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [IDX_W-1:0]            push_idx_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  logic [BIAS_W_W-1:0]         cap_w_i,
  input  logic                        wb_vld_i,
  input  logic [IDX_W-1:0]            wb_idx_i,
  input  logic [BIAS_W_W-1:0]         wb_w_i,
  input  logic                        fwd_vld_i,
  input  logic [IDX_W-1:0]            fwd_idx_i,
  input  logic [BIAS_W_W-1:0]         fwd_w_i,
  output logic [IDX_W-1:0]            head_idx_o,
  output logic [BIAS_W_W-1:0]         head_w_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]       wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [AW-1:0]       wr_slot, rd_slot, cap_slot_q, off;
  logic                wcap_q, full, push_ok, pop_ok, head_pend, cap_en;
  logic [BIAS_W_W-1:0] cap_w;
  logic [DEPTH-1:0]    live;
  logic [IDX_W-1:0]    idx_q [DEPTH];
  logic [BIAS_W_W-1:0] w_q   [DEPTH];

  assign wr_slot  = wr_ptr_q[AW-1:0];
  assign rd_slot  = rd_ptr_q[AW-1:0];
  assign count_o  = wr_ptr_q - rd_ptr_q;
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_slot == rd_slot) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push_ok  = push_i && !full;
  assign pop_ok   = pop_i && !empty_o;

  // A lookup issued while its own index was being written read the old table value.
  assign cap_w      = (wb_vld_i && idx_q[cap_slot_q] == wb_idx_i) ? wb_w_i : cap_w_i;
  assign head_pend  = wcap_q && (cap_slot_q == rd_slot) && !empty_o;
  assign cap_en     = wcap_q && !flush_i && !(pop_ok && head_pend);
  assign head_idx_o = idx_q[rd_slot];
  assign head_w_o   = head_pend ? cap_w : w_q[rd_slot];

  always_comb begin
    live = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off     = AW'(i) - rd_slot;
      live[i] = ({1'b0, off} < count_o) && !(pop_ok && off == '0);
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    wr_ptr_d = flush_i ? rd_ptr_d : wr_ptr_q + PW'(push_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wcap_q     <= 1'b0;
      cap_slot_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wcap_q   <= push_ok && !flush_i;
      if (push_ok) cap_slot_q <= wr_slot;
    end
  end

  // Forwarding is applied after capture so it wins for a same-edge captured slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cap_en && cap_slot_q == AW'(i)) w_q[i] <= cap_w;
      if (fwd_vld_i && live[i] && idx_q[i] == fwd_idx_i) w_q[i] <= fwd_w_i;
    end
    if (push_ok) begin
      idx_q[wr_slot] <= push_idx_i;
      w_q[wr_slot]   <= '0;
    end
  end
endmodule

// File: rtl/bias_weight_trainer.sv
// Bias weight trainer: queues lookups, writes saturated weight one cycle after resolve.
// pred_ready = count < DEPTH; BIAS_FWD_EN forwards each write into aliased queued entries.
module bias_weight_trainer
  import bias_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = BIAS_IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  input  logic [IDX_W-1:0]    index,
  output logic                pred_ready,
  input  logic [BIAS_W_W-1:0] weight,
  input  logic                res_valid,
  input  logic                res_taken,
  input  logic                flush,
  output logic [IDX_W-1:0]    index_update,
  output logic [BIAS_W_W-1:0] weight_update,
  output logic                en_1,
  output logic                res_underflow
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0]       count;
  logic                empty, pop, fwd_vld, wb_vld;
  logic                en_1_q, en_1_d, uf_q, uf_d;
  logic [IDX_W-1:0]    head_idx, idx_upd_q, idx_upd_d;
  logic [BIAS_W_W-1:0] head_w, new_w, w_upd_q, w_upd_d;

  assign pred_ready = (count < PW'(DEPTH));
  assign pop        = res_valid && !empty;
  assign new_w      = bias_sat_update(head_w, res_taken);

  always_comb begin
    en_1_d    = pop && (new_w != head_w);
    idx_upd_d = en_1_d ? head_idx : idx_upd_q;
    w_upd_d   = en_1_d ? new_w : w_upd_q;
    uf_d      = res_valid && empty;
  end

`ifdef BIAS_FWD_EN
  assign fwd_vld = en_1_d;
  assign wb_vld  = en_1_q;
`else
  assign fwd_vld = 1'b0;
  assign wb_vld  = 1'b0;
`endif

  bias_inflight_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (pred_valid && pred_ready),
    .push_idx_i (index),
    .pop_i      (res_valid),
    .flush_i    (flush),
    .cap_w_i    (weight),
    .wb_vld_i   (wb_vld),
    .wb_idx_i   (idx_upd_q),
    .wb_w_i     (w_upd_q),
    .fwd_vld_i  (fwd_vld),
    .fwd_idx_i  (idx_upd_d),
    .fwd_w_i    (w_upd_d),
    .head_idx_o (head_idx),
    .head_w_o   (head_w),
    .empty_o    (empty),
    .count_o    (count)
  );

  // Write port is fully registered so it is stable through the table's negedge commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_1_q    <= 1'b0;
      idx_upd_q <= '0;
      w_upd_q   <= '0;
      uf_q      <= 1'b0;
    end else begin
      en_1_q    <= en_1_d;
      idx_upd_q <= idx_upd_d;
      w_upd_q   <= w_upd_d;
      uf_q      <= uf_d;
    end
  end

  assign en_1          = en_1_q;
  assign index_update  = idx_upd_q;
  assign weight_update = w_upd_q;
  assign res_underflow = uf_q;
endmodule

// File: tb/tb_bias_weight_trainer.sv
// Scoreboard bench for bias_weight_trainer: queue-level reference model plus randomized traffic.
module tb_bias_weight_trainer;
  localparam int DEPTH = 8;
  localparam int IDX_W = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pred_valid = 1'b0, res_valid = 1'b0, res_taken = 1'b0, flush = 1'b0;
  logic [IDX_W-1:0] index = '0;
  logic [1:0]       weight = '0;
  logic             pred_ready, en_1, res_underflow;
  logic [IDX_W-1:0] index_update;
  logic [1:0]       weight_update;

  bias_weight_trainer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_valid    (pred_valid),
    .index         (index),
    .pred_ready    (pred_ready),
    .weight        (weight),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .flush         (flush),
    .index_update  (index_update),
    .weight_update (weight_update),
    .en_1          (en_1),
    .res_underflow (res_underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [IDX_W-1:0] idx; int w; bit pend;} ent_t;
  typedef struct {int cyc; logic [IDX_W-1:0] idx; int w;} wr_t;

  ent_t             mq[$];
  wr_t              exp_wr[$];
  int               exp_uf[$];
  int               checks = 0, errors = 0;
  bit               mon_en = 1'b0;
  bit               lw_vld = 1'b0;
  logic [IDX_W-1:0] lw_idx = '0;
  int               lw_w = 0;
  wr_t              me;
  int               mu;

  function automatic int sat(int w, bit t);
    if (t) return (w >= 3) ? 3 : w + 1;
    return (w <= 0) ? 0 : w - 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model applies the same cycle's effect to its queue.
  task automatic step(bit pv, int ix, int w, bit rv, bit rt, bit fl, bit rs);
    bit   rdy, wrote;
    int   nw, wv;
    ent_t e;
    wv         = w & 3;
    pred_valid = pv;
    index      = IDX_W'(ix);
    weight     = 2'(wv);
    res_valid  = rv;
    res_taken  = rt;
    flush      = fl;
    rst        = rs;
    rdy        = mq.size() < DEPTH;
    chk("pred_ready", int'(pred_ready), int'(rdy));
    wrote = 1'b0;
    if (rs) begin
      mq.delete();
      lw_vld = 1'b0;
    end else begin
      foreach (mq[i]) if (mq[i].pend) begin
`ifdef BIAS_FWD_EN
        mq[i].w = (lw_vld && lw_idx == mq[i].idx) ? lw_w : wv;
`else
        mq[i].w = wv;
`endif
        mq[i].pend = 1'b0;
      end
      if (rv) begin
        if (mq.size() == 0) exp_uf.push_back(cyc + 1);
        else begin
          e  = mq.pop_front();
          nw = sat(e.w, rt);
          if (nw != e.w) begin
            exp_wr.push_back('{cyc + 1, e.idx, nw});
            wrote  = 1'b1;
            lw_idx = e.idx;
            lw_w   = nw;
`ifdef BIAS_FWD_EN
            foreach (mq[i]) if (mq[i].idx == e.idx) mq[i].w = nw;
`endif
          end
        end
      end
      lw_vld = wrote;
      if (fl) mq.delete();
      else if (pv && rdy) mq.push_back('{IDX_W'(ix), 0, 1'b1});
    end
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) if (mon_en) begin
    if (en_1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got idx=%0d w=%0d expected no write", index_update, weight_update);
      end else begin
        me = exp_wr.pop_front();
        if (me.cyc != cyc || me.idx != index_update || me.w != int'(weight_update)) begin
          errors++;
          $display("FAIL write: got cyc=%0d idx=%0d w=%0d expected cyc=%0d idx=%0d w=%0d",
                   cyc, index_update, weight_update, me.cyc, me.idx, me.w);
        end
      end
    end
    while (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
      me = exp_wr.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write: got none expected idx=%0d w=%0d at cyc=%0d", me.idx, me.w, me.cyc);
    end
    if (res_underflow) begin
      checks++;
      if (exp_uf.size() == 0) begin
        errors++;
        $display("FAIL unexpected_underflow: got pulse at cyc=%0d expected none", cyc);
      end else begin
        mu = exp_uf.pop_front();
        if (mu != cyc) begin
          errors++;
          $display("FAIL underflow: got cyc=%0d expected cyc=%0d", cyc, mu);
        end
      end
    end
    while (exp_uf.size() > 0 && exp_uf[0] <= cyc) begin
      mu = exp_uf.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_underflow: got none expected pulse at cyc=%0d", mu);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_en_1", int'(en_1), 0);
    chk("rst_index_update", int'(index_update), 0);
    chk("rst_weight_update", int'(weight_update), 0);
    chk("rst_underflow", int'(res_underflow), 0);
    chk("rst_pred_ready", int'(pred_ready), 1);
    mon_en = 1'b1;

    // Basic taken update: index 5, weight 1 -> write 2.
    step(1, 5, $urandom_range(0, 3), 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Saturated heads produce no write.
    step(1, 20, $urandom_range(0, 3), 0, 0, 0, 0);
    step(0, 0, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(1, 21, $urandom_range(0, 3), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);

    // Fill to DEPTH, one dropped extra lookup, drain in order, then underflow.
    for (int i = 0; i < DEPTH + 1; i++) step(1, 100 + i, $urandom_range(0, 3), 0, 0, 0, 0);
    chk("full_pred_ready", int'(pred_ready), 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, $urandom_range(0, 3), 1, 1'($urandom_range(0, 1)), 0, 0);
    chk("drained_pred_ready", int'(pred_ready), 1);
    step(0, 0, 0, 1, 1, 0, 0);

    // Resolve in the capture cycle uses the live weight.
    step(1, 7, $urandom_range(0, 3), 0, 0, 0, 0);
    step(0, 0, 2, 1, 1, 0, 0);

    // Resolve + flush: only head writes, queue empties, next resolve underflows.
    step(1, 30, $urandom_range(0, 3), 0, 0, 0, 0);
    step(1, 31, 1, 0, 0, 0, 0);
    step(1, 32, 2, 0, 0, 0, 0);
    step(0, 0, 3, 1, 1, 1, 0);
    chk("flush_pred_ready", int'(pred_ready), 1);
    step(0, 0, 0, 1, 0, 0, 0);

    // Aliased index 9.
    step(1, 9, $urandom_range(0, 3), 0, 0, 0, 0);
    step(1, 9, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-operation suppresses the resolve's write.
    step(1, 40, $urandom_range(0, 3), 0, 0, 0, 0);
    step(1, 41, 1, 0, 0, 0, 0);
    step(0, 0, 2, 1, 1, 0, 1);
    chk("midrst_en_1", int'(en_1), 0);
    chk("midrst_index_update", int'(index_update), 0);
    step(0, 0, 0, 1, 1, 0, 0);

    // Randomized traffic with heavy index aliasing.
    for (int n = 0; n < 800; n++) begin
      step(bit'($urandom_range(0, 99) < 60),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 15)),
           $urandom_range(0, 3),
           bit'($urandom_range(0, 99) < 45),
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 99) < 4),
           1'b0);
    end

    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("leftover_expectations", exp_wr.size() + exp_uf.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
